// File: rtl/updown_ctrl_pkg.sv
// Shared encodings for the up/down count arbiter: FSM states, direction and pointer values.
package updown_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;
endpackage

// File: rtl/updown_step_counter.sv
// Shared up/down step counter; saturating by default, wrapping when COUNT_WRAP_EN is defined.
module updown_step_counter
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;

  // clr wins over a step issued in the same cycle
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (step_en) begin
      if (dir == DIR_UP) begin
`ifdef COUNT_WRAP_EN
        count_d = count_q + ONE;
`else
        if (count_q != CMAX) count_d = count_q + ONE;
`endif
      end else begin
`ifdef COUNT_WRAP_EN
        count_d = count_q - ONE;
`else
        if (count_q != '0) count_d = count_q - ONE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/updown_count_arbiter.sv
// Two-requester round-robin arbiter with burst limit driving a shared up/down counter.
// Optional macro COUNT_WRAP_EN selects wrapping instead of saturating count.
module updown_count_arbiter
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       dir,
  input  logic             clr,
  output logic [1:0]       grant,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min
);
  localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] BONE  = BW'(1);

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          step_en, step_dir;
  logic          burst_last;

  assign burst_last = (burst_q == BLAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PTR_A;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  // Pointer always names the requester that did not receive the latest grant
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        burst_d = '0;
        if (req[0] && (!req[1] || ptr_q == PTR_A)) begin
          state_d = OWN_A;
          ptr_d   = PTR_B;
        end else if (req[1]) begin
          state_d = OWN_B;
          ptr_d   = PTR_A;
        end
      end
      OWN_A: begin
        if (!req[0]) begin
          state_d = IDLE;
          ptr_d   = PTR_B;
          burst_d = '0;
        end else if (burst_last) begin
          burst_d = '0;
          if (req[1]) begin
            state_d = OWN_B;
            ptr_d   = PTR_A;
          end
        end else begin
          burst_d = burst_q + BONE;
        end
      end
      OWN_B: begin
        if (!req[1]) begin
          state_d = IDLE;
          ptr_d   = PTR_A;
          burst_d = '0;
        end else if (burst_last) begin
          burst_d = '0;
          if (req[0]) begin
            state_d = OWN_A;
            ptr_d   = PTR_B;
          end
        end else begin
          burst_d = burst_q + BONE;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_comb begin
    grant    = 2'b00;
    step_en  = 1'b0;
    step_dir = DIR_DOWN;
    case (state_q)
      OWN_A: begin
        grant    = 2'b01;
        step_en  = req[0];
        step_dir = dir[0];
      end
      OWN_B: begin
        grant    = 2'b10;
        step_en  = req[1];
        step_dir = dir[1];
      end
      default: ;
    endcase
  end

  updown_step_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .step_en (step_en),
    .dir     (step_dir),
    .clr     (clr),
    .count   (count)
  );

  assign at_max = (count == {WIDTH{1'b1}});
  assign at_min = (count == '0);
endmodule

// File: tb/tb_updown_count_arbiter.sv
// Vector table plus scoreboard bench for updown_count_arbiter at WIDTH=2, MAX_BURST=4.
module tb_updown_count_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] dir = 2'b00;
  logic       clr = 1'b0;
  logic [1:0] grant;
  logic [1:0] count;
  logic       at_max, at_min;

`ifdef COUNT_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] dir;
    logic       clr;
    logic [1:0] g;
    logic [1:0] c;
  } vec_t;

  typedef struct {
    logic [1:0] g;
    logic [1:0] c;
    logic       mx;
    logic       mn;
    int         idx;
  } exp_t;

  localparam int NV = 26;
  vec_t tbl [NV];
  exp_t sb [$];
  int total = 0;
  int bad = 0;

  updown_count_arbiter #(.WIDTH(2), .MAX_BURST(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .dir    (dir),
    .clr    (clr),
    .grant  (grant),
    .count  (count),
    .at_max (at_max),
    .at_min (at_min)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s vec %0d: actual=%0d required=%0d", nm, idx, act, req_v);
    end
  endtask

  // Drive one cycle of inputs, queue its expected result, compare after the edge
  task automatic apply(input int idx, input vec_t v);
    exp_t e, got;
    @(negedge clk);
    reset = v.rst; req = v.req; dir = v.dir; clr = v.clr;
    e.g = v.g; e.c = v.c; e.mx = (v.c == 2'd3); e.mn = (v.c == 2'd0); e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard vec %0d: actual=empty required=entry", idx);
    end else begin
      got = sb.pop_front();
      chk("grant",  got.idx, grant, got.g);
      chk("count",  got.idx, count, got.c);
      chk("at_max", got.idx, {1'b0, at_max}, {1'b0, got.mx});
      chk("at_min", got.idx, {1'b0, at_min}, {1'b0, got.mn});
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [1:0] rq, input logic [1:0] dr,
                              input logic cl, input logic [1:0] g, input logic [1:0] c);
    vec_t v;
    v.rst = rst; v.req = rq; v.dir = dr; v.clr = cl; v.g = g; v.c = c;
    return v;
  endfunction

  initial begin
    // A alone counting up, then saturation / wrap at the top
    tbl[0]  = mk(1, 2'b00, 2'b00, 0, 2'b00, 2'd0);
    tbl[1]  = mk(0, 2'b01, 2'b01, 0, 2'b01, 2'd0);
    tbl[2]  = mk(0, 2'b01, 2'b01, 0, 2'b01, 2'd1);
    tbl[3]  = mk(0, 2'b01, 2'b01, 0, 2'b01, 2'd2);
    tbl[4]  = mk(0, 2'b01, 2'b01, 0, 2'b01, 2'd3);
    tbl[5]  = mk(0, 2'b01, 2'b01, 0, 2'b01, WRAP ? 2'd0 : 2'd3);
    tbl[6]  = mk(0, 2'b01, 2'b01, 0, 2'b01, WRAP ? 2'd1 : 2'd3);
    tbl[7]  = mk(0, 2'b00, 2'b01, 0, 2'b00, WRAP ? 2'd1 : 2'd3);
    // Both requesting: A first, down at 0, burst handoff to B with no idle gap
    tbl[8]  = mk(1, 2'b00, 2'b00, 0, 2'b00, 2'd0);
    tbl[9]  = mk(0, 2'b11, 2'b10, 0, 2'b01, 2'd0);
    tbl[10] = mk(0, 2'b11, 2'b10, 0, 2'b01, WRAP ? 2'd3 : 2'd0);
    tbl[11] = mk(0, 2'b11, 2'b10, 0, 2'b01, WRAP ? 2'd2 : 2'd0);
    tbl[12] = mk(0, 2'b11, 2'b10, 0, 2'b01, WRAP ? 2'd1 : 2'd0);
    tbl[13] = mk(0, 2'b11, 2'b10, 0, 2'b10, 2'd0);
    tbl[14] = mk(0, 2'b11, 2'b10, 0, 2'b10, 2'd1);
    tbl[15] = mk(0, 2'b11, 2'b10, 0, 2'b10, 2'd2);
    // B drops with A waiting: one idle cycle, no step
    tbl[16] = mk(0, 2'b01, 2'b10, 0, 2'b00, 2'd2);
    tbl[17] = mk(0, 2'b01, 2'b10, 0, 2'b01, 2'd2);
    // clr overrides a same-cycle up step
    tbl[18] = mk(0, 2'b01, 2'b01, 1, 2'b01, 2'd0);
    tbl[19] = mk(0, 2'b01, 2'b01, 0, 2'b01, 2'd1);
    // Reset mid-burst of B discards the step; pointer back to A
    tbl[20] = mk(0, 2'b10, 2'b10, 0, 2'b00, 2'd1);
    tbl[21] = mk(0, 2'b10, 2'b10, 0, 2'b10, 2'd1);
    tbl[22] = mk(0, 2'b10, 2'b10, 0, 2'b10, 2'd2);
    tbl[23] = mk(1, 2'b10, 2'b10, 0, 2'b00, 2'd0);
    tbl[24] = mk(0, 2'b11, 2'b00, 0, 2'b01, 2'd0);
    tbl[25] = mk(0, 2'b00, 2'b00, 0, 2'b00, 2'd0);

    for (int i = 0; i < NV; i++) apply(i, tbl[i]);

    // B owns first, hits burst limit while A waits, hands off to A
    apply(100, mk(1, 2'b00, 2'b00, 0, 2'b00, 2'd0));
    apply(101, mk(0, 2'b10, 2'b10, 0, 2'b10, 2'd0));
    apply(102, mk(0, 2'b11, 2'b10, 0, 2'b10, 2'd1));
    apply(103, mk(0, 2'b11, 2'b10, 0, 2'b10, 2'd2));
    apply(104, mk(0, 2'b11, 2'b10, 0, 2'b10, 2'd3));
    apply(105, mk(0, 2'b11, 2'b10, 0, 2'b01, WRAP ? 2'd0 : 2'd3));
    apply(106, mk(0, 2'b11, 2'b10, 0, 2'b01, WRAP ? 2'd3 : 2'd2));
    apply(107, mk(0, 2'b00, 2'b10, 0, 2'b00, WRAP ? 2'd3 : 2'd2));
    // clr in idle, reset overriding clr and req
    apply(108, mk(0, 2'b00, 2'b00, 1, 2'b00, 2'd0));
    apply(109, mk(1, 2'b11, 2'b11, 1, 2'b00, 2'd0));
    apply(110, mk(0, 2'b10, 2'b11, 0, 2'b10, 2'd0));
    apply(111, mk(0, 2'b10, 2'b11, 0, 2'b10, 2'd1));

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/updown_count_arbiter.md
UPDOWN_COUNT_ARBITER -- requirements
Module: updown_count_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 2, counter width in bits.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive steps per grant while the other requester waits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  2  step request, bit 0 = requester A, bit 1 = requester B.
REQ-006 SHALL have port dir  input  2  step direction per requester, 1 = up, 0 = down.
REQ-007 SHALL have port clr  input  1  synchronous clear of the shared count.
REQ-008 SHALL have port grant  output  2  registered one-hot grant; 00 when idle.
REQ-009 SHALL have port count  output  WIDTH  shared counter value.
REQ-010 SHALL have port at_max / at_min  output  1 each  count equals 2^WIDTH-1 / 0.

Function
REQ-011 SHALL implement FSM states IDLE, OWN_A, OWN_B; grant = 01 in OWN_A, 10 in OWN_B, 00 in IDLE.
REQ-012 IDLE: req = 00 -> stay; one bit set -> own that requester; both set -> own the requester selected by round-robin pointer.
REQ-013 Pointer SHALL name the requester not most recently granted; after reset it names A.
REQ-014 A step SHALL occur at the edge ending any cycle where grant[i]=1 and req[i]=1; count moves +1 (dir[i]=1) or -1 (dir[i]=0).
REQ-015 Latency: req asserted in IDLE at cycle t -> grant at t+1 -> count changed at t+2.
REQ-016 Owned requester with req[i]=0 -> IDLE next cycle, no step; pointer set to the other requester.
REQ-017 SHALL count steps in the current grant; after MAX_BURST steps with other req high, SHALL switch directly to the other OWN state (no IDLE cycle) and zero the burst count.
REQ-018 Burst limit reached with other req low -> remain owner, zero burst count.
REQ-019 Without COUNT_WRAP_EN, up at 2^WIDTH-1 and down at 0 SHALL hold count; the step still consumes a burst slot.
REQ-020 clr=1 SHALL force count to 0 at next edge, overriding any simultaneous step; FSM, grant, pointer and burst count unaffected.
REQ-021 dir changes during ownership SHALL take effect on the same-cycle step.
REQ-022 at_max / at_min SHALL be combinational from count.

Reset
REQ-023 reset=1 SHALL set at the next edge: state IDLE, grant 00, count 0, burst count 0, pointer A; overrides clr and req.
REQ-024 Reset asserted mid-burst SHALL discard the pending step in that cycle.

Configuration
REQ-025 Macro COUNT_WRAP_EN defined: up from 2^WIDTH-1 -> 0, down from 0 -> 2^WIDTH-1.
REQ-026 Macro COUNT_WRAP_EN undefined: saturating behaviour per REQ-019; all other behaviour identical.

Structure
REQ-027 Shared package updown_ctrl_pkg SHALL hold the FSM state encoding (IDLE=00, OWN_A=01, OWN_B=10) and DIR_UP/DIR_DOWN constants.
REQ-028 Counter datapath SHALL be sub-module updown_step_counter (inputs step_en, dir, clr, reset; output count); the arbiter FSM stays in the top module.

Verification
REQ-029 Reset then req=01, dir=01 for 3 cycles, WIDTH=2 -> grant=01 at t+1, count 1,2,3 at t+2..t+4; at_max=1 at count 3.
REQ-030 count=3, owner A, dir[0]=1 held 2 more cycles -> count stays 3 (saturate); with COUNT_WRAP_EN count 0 then 1.
REQ-031 req=11 from IDLE after reset, dir=10 -> A granted first, A steps down (saturating at 0), after 4 steps grant=10 on next cycle with no IDLE gap, B steps up.
REQ-032 Owner B, req[1] drops, req[0] stays high -> IDLE one cycle, then grant=01; no step during the drop cycle.
REQ-033 Owner A stepping up at count=2 with clr=1 same cycle -> count=0 next edge, grant remains 01.
REQ-034 reset pulsed during OWN_B burst with count=2 -> next cycle grant=00, count=0; following req=11 grants A.
